ysyx_22051013_axi_arbiter: RTL and testbench
============================================

YSYX_22051013_AXI_ARBITER -- requirements
Module: ysyx_22051013_axi_arbiter

Interface
REQ-001 Parameter ADDR_W, 64, address width of every AR/AW channel.
REQ-002 Parameter DATA_W, 64, data width of every R/W channel; STRB width SHALL be DATA_W/8.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 ifu_ar_{addr,valid} in ADDR_W/1, ifu_ar_ready out 1: IFU read address channel (slave side of arbiter).
REQ-006 ifu_r_{data,resp,valid} out DATA_W/2/1, ifu_r_ready in 1: IFU read data channel.
REQ-007 lsu_ar_{addr,valid} in ADDR_W/1, lsu_ar_ready out 1: LSU read address channel.
REQ-008 lsu_r_{data,resp,valid} out DATA_W/2/1, lsu_r_ready in 1: LSU read data channel.
REQ-009 lsu_aw_*, lsu_w_{data,strb,valid}/lsu_w_ready, lsu_b_{resp,valid}/lsu_b_ready: LSU write channels, standard AXI-lite directions.
REQ-010 mem_ar_*, mem_r_*, mem_aw_*, mem_w_*, mem_b_*: master-side channels to the single memory slave, mirror directions.

Function
REQ-011 Read FSM SHALL have states IDLE, ADDR, DATA; grant register SHALL be IFU or LSU.
REQ-012 IDLE: if any ar_valid, latch grantee, go ADDR next cycle; no mem_ar_valid asserted in IDLE.
REQ-013 Fixed priority (default): LSU wins when both ifu_ar_valid and lsu_ar_valid are high in the same IDLE cycle.
REQ-014 ADDR: mem_ar_addr/valid SHALL equal grantee's ar_addr/valid; grantee's ar_ready = mem_ar_ready; on mem AR handshake go DATA.
REQ-015 DATA: mem_r_* routed to grantee; mem_r_ready = grantee's r_ready; on R handshake go IDLE.
REQ-016 Non-granted master SHALL see ar_ready=0 and r_valid=0 at all times; its r_data/r_resp SHALL be zero.
REQ-017 Minimum read latency: ar_valid in IDLE -> mem_ar_valid one cycle later; one read outstanding at most.
REQ-018 Grantee deasserting ar_valid in ADDR (protocol violation) SHALL leave FSM in ADDR with grant unchanged.
REQ-019 A request arriving during ADDR/DATA SHALL wait; it is served from the next IDLE.
REQ-020 Write channels SHALL be combinational pass-through LSU<->mem, independent of read FSM; IFU never writes.
REQ-021 mem_r_resp/mem_b_resp SHALL be forwarded unmodified.

Reset
REQ-022 On rst: FSM=IDLE, grant=IFU, last-grant=IFU; mem_ar_valid, ifu/lsu_ar_ready, ifu/lsu_r_valid, mem_r_ready = 0; all read data/resp outputs = 0.
REQ-023 Reset mid-transaction SHALL abandon the transfer; no response is delivered after reset release.

Configuration
REQ-024 With YSYX_22051013_ARB_RR_EN defined: on simultaneous requests grant SHALL go to the master not granted last; last-grant updates on each IDLE->ADDR.
REQ-025 Without YSYX_22051013_ARB_RR_EN: fixed LSU priority per REQ-013; last-grant register SHALL not exist.

Structure
REQ-026 FSM state encodings (S_IDLE/S_ADDR/S_DATA) and grant encoding SHALL live in the shared AXI define header with the existing channel width macros.
REQ-027 No sub-module; read FSM and write pass-through in one module.

Verification
REQ-028 IFU alone reads 0x8000_0000, mem returns 0xDEAD_BEEF_0000_0001 -> ifu_r_data matches, lsu_r_valid stays 0, mem_ar_valid rises 1 cycle after ifu_ar_valid.
REQ-029 IFU and LSU request same cycle (0x8000_0000 / 0x8000_1000), fixed priority -> LSU served first, IFU second, order checked at mem_ar_addr.
REQ-030 RR build, both requesting continuously for 4 transactions -> grants alternate LSU, IFU, LSU, IFU.
REQ-031 mem_r_valid held while lsu_r_ready=0 for 3 cycles -> FSM stays DATA, no IFU grant until handshake.
REQ-032 LSU write 0x8000_2000, data 0x11, strb 0x01, concurrent with IFU read -> both complete, b_resp=0, read unaffected.
REQ-033 rst asserted in DATA state -> all valids 0 same cycle, FSM IDLE, next request served normally.

Source files
------------

// File: rtl/ysyx_22051013_axi_arbiter_pkg.sv
// ysyx_22051013_axi_arbiter_pkg: shared AXI widths plus read-arbiter state and grant encodings.
package ysyx_22051013_axi_arbiter_pkg;
  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_RESP_W = 2;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;
  typedef enum logic {
    G_IFU = 1'b0,
    G_LSU = 1'b1
  } grant_t;
endpackage

// File: rtl/ysyx_22051013_axi_arbiter.sv
// ysyx_22051013_axi_arbiter: IFU/LSU read arbiter onto one AXI-lite memory port, LSU writes pass through.
// Define YSYX_22051013_ARB_RR_EN for round-robin on simultaneous reads; default is fixed LSU priority.
module ysyx_22051013_axi_arbiter
  import ysyx_22051013_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     ifu_ar_addr,
  input  logic                  ifu_ar_valid,
  output logic                  ifu_ar_ready,
  output logic [DATA_W-1:0]     ifu_r_data,
  output logic [AXI_RESP_W-1:0] ifu_r_resp,
  output logic                  ifu_r_valid,
  input  logic                  ifu_r_ready,
  input  logic [ADDR_W-1:0]     lsu_ar_addr,
  input  logic                  lsu_ar_valid,
  output logic                  lsu_ar_ready,
  output logic [DATA_W-1:0]     lsu_r_data,
  output logic [AXI_RESP_W-1:0] lsu_r_resp,
  output logic                  lsu_r_valid,
  input  logic                  lsu_r_ready,
  input  logic [ADDR_W-1:0]     lsu_aw_addr,
  input  logic                  lsu_aw_valid,
  output logic                  lsu_aw_ready,
  input  logic [DATA_W-1:0]     lsu_w_data,
  input  logic [DATA_W/8-1:0]   lsu_w_strb,
  input  logic                  lsu_w_valid,
  output logic                  lsu_w_ready,
  output logic [AXI_RESP_W-1:0] lsu_b_resp,
  output logic                  lsu_b_valid,
  input  logic                  lsu_b_ready,
  output logic [ADDR_W-1:0]     mem_ar_addr,
  output logic                  mem_ar_valid,
  input  logic                  mem_ar_ready,
  input  logic [DATA_W-1:0]     mem_r_data,
  input  logic [AXI_RESP_W-1:0] mem_r_resp,
  input  logic                  mem_r_valid,
  output logic                  mem_r_ready,
  output logic [ADDR_W-1:0]     mem_aw_addr,
  output logic                  mem_aw_valid,
  input  logic                  mem_aw_ready,
  output logic [DATA_W-1:0]     mem_w_data,
  output logic [DATA_W/8-1:0]   mem_w_strb,
  output logic                  mem_w_valid,
  input  logic                  mem_w_ready,
  input  logic [AXI_RESP_W-1:0] mem_b_resp,
  input  logic                  mem_b_valid,
  output logic                  mem_b_ready
);
  state_t state, state_nxt;
  grant_t grant, pick;
  logic   any_req, is_lsu, g_ar_valid, g_r_ready, in_addr, in_data;
  assign any_req = ifu_ar_valid | lsu_ar_valid;
`ifdef YSYX_22051013_ARB_RR_EN
  grant_t last;
  always_comb
    pick = (ifu_ar_valid & lsu_ar_valid) ? ((last == G_LSU) ? G_IFU : G_LSU)
                                         : (lsu_ar_valid ? G_LSU : G_IFU);
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= G_IFU;
    else if (state == S_IDLE && any_req) last <= pick;
`else
  always_comb pick = lsu_ar_valid ? G_LSU : G_IFU;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      grant <= G_IFU;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_req) grant <= pick;
    end
  always_comb begin
    is_lsu     = grant == G_LSU;
    g_ar_valid = is_lsu ? lsu_ar_valid : ifu_ar_valid;
    g_r_ready  = is_lsu ? lsu_r_ready : ifu_r_ready;
    state_nxt  = (state == S_IDLE && any_req)                    ? S_ADDR :
                 (state == S_ADDR && g_ar_valid && mem_ar_ready) ? S_DATA :
                 (state == S_DATA && mem_r_valid && g_r_ready)   ? S_IDLE : state;
  end
  // Everything read-side is gated by state so the loser, and both masters after reset, see zeros.
  always_comb begin
    in_addr      = state == S_ADDR;
    in_data      = state == S_DATA;
    mem_ar_valid = in_addr & g_ar_valid;
    mem_ar_addr  = in_addr ? (is_lsu ? lsu_ar_addr : ifu_ar_addr) : '0;
    ifu_ar_ready = in_addr & ~is_lsu & mem_ar_ready;
    lsu_ar_ready = in_addr & is_lsu & mem_ar_ready;
    mem_r_ready  = in_data & g_r_ready;
    ifu_r_valid  = in_data & ~is_lsu & mem_r_valid;
    lsu_r_valid  = in_data & is_lsu & mem_r_valid;
    ifu_r_data   = (in_data & ~is_lsu) ? mem_r_data : '0;
    lsu_r_data   = (in_data & is_lsu) ? mem_r_data : '0;
    ifu_r_resp   = (in_data & ~is_lsu) ? mem_r_resp : '0;
    lsu_r_resp   = (in_data & is_lsu) ? mem_r_resp : '0;
  end
  assign mem_aw_addr  = lsu_aw_addr;
  assign mem_aw_valid = lsu_aw_valid;
  assign lsu_aw_ready = mem_aw_ready;
  assign mem_w_data   = lsu_w_data;
  assign mem_w_strb   = lsu_w_strb;
  assign mem_w_valid  = lsu_w_valid;
  assign lsu_w_ready  = mem_w_ready;
  assign lsu_b_resp   = mem_b_resp;
  assign lsu_b_valid  = mem_b_valid;
  assign mem_b_ready  = lsu_b_ready;
endmodule

// File: tb/tb_ysyx_22051013_axi_arbiter.sv
// tb_ysyx_22051013_axi_arbiter: random IFU/LSU/memory agents checked against a transaction-level arbitration model.
module tb_ysyx_22051013_axi_arbiter;
  logic        clk = 1'b0, rst;
  logic [63:0] ifu_ar_addr, lsu_ar_addr, mem_ar_addr, lsu_aw_addr, mem_aw_addr;
  logic        ifu_ar_valid, ifu_ar_ready, lsu_ar_valid, lsu_ar_ready, mem_ar_valid, mem_ar_ready;
  logic [63:0] ifu_r_data, lsu_r_data, mem_r_data, lsu_w_data, mem_w_data;
  logic [1:0]  ifu_r_resp, lsu_r_resp, mem_r_resp, lsu_b_resp, mem_b_resp;
  logic        ifu_r_valid, ifu_r_ready, lsu_r_valid, lsu_r_ready, mem_r_valid, mem_r_ready;
  logic        lsu_aw_valid, lsu_aw_ready, mem_aw_valid, mem_aw_ready;
  logic [7:0]  lsu_w_strb, mem_w_strb;
  logic        lsu_w_valid, lsu_w_ready, mem_w_valid, mem_w_ready;
  logic        lsu_b_valid, lsu_b_ready, mem_b_valid, mem_b_ready;

  ysyx_22051013_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_ar_addr(ifu_ar_addr), .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready),
    .ifu_r_data(ifu_r_data), .ifu_r_resp(ifu_r_resp), .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready),
    .lsu_ar_addr(lsu_ar_addr), .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready),
    .lsu_r_data(lsu_r_data), .lsu_r_resp(lsu_r_resp), .lsu_r_valid(lsu_r_valid), .lsu_r_ready(lsu_r_ready),
    .lsu_aw_addr(lsu_aw_addr), .lsu_aw_valid(lsu_aw_valid), .lsu_aw_ready(lsu_aw_ready),
    .lsu_w_data(lsu_w_data), .lsu_w_strb(lsu_w_strb), .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready),
    .lsu_b_resp(lsu_b_resp), .lsu_b_valid(lsu_b_valid), .lsu_b_ready(lsu_b_ready),
    .mem_ar_addr(mem_ar_addr), .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
    .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp), .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready),
    .mem_aw_addr(mem_aw_addr), .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready),
    .mem_w_data(mem_w_data), .mem_w_strb(mem_w_strb), .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
    .mem_b_resp(mem_b_resp), .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // agent states: 0 idle, 1 address pending, 2 awaiting data; memory: 0 wait AR, 1 latency, 2 data valid
  int          i_st, l_st, m_st, m_dly, lsu_stall, req_pct;
  logic [63:0] i_addr, l_addr, i_exp, l_exp, m_data, fixed_data;
  logic [1:0]  m_resp;
  logic        busy, ar_done, g, last, keep, fixed_en, wfix;
  logic        gq[$];
  logic [63:0] arq[$];

  function automatic logic [63:0] fdat(input logic [63:0] a);
    return {~a[31:0], a[31:0] ^ 32'h5a5a_a5a5};
  endfunction

  task automatic model_reset();
    i_st = 0; l_st = 0; m_st = 0; m_dly = 0; busy = 0; ar_done = 0; g = 0; last = 0;
    lsu_stall = 0; keep = 0;
    gq.delete(); arq.delete();
  endtask

  task automatic cycle();
    logic [63:0] a;
    ifu_ar_valid = i_st == 1; ifu_ar_addr = i_addr;
    lsu_ar_valid = l_st == 1; lsu_ar_addr = l_addr;
    ifu_r_ready  = $urandom_range(3) != 0;
    lsu_r_ready  = lsu_stall > 0 ? 1'b0 : $urandom_range(3) != 0;
    mem_ar_ready = m_st == 0 && $urandom_range(2) != 0;
    mem_r_valid  = m_st == 2;
    mem_r_data   = m_st == 2 ? m_data : {$urandom, $urandom};
    mem_r_resp   = m_st == 2 ? m_resp : 2'($urandom);
    lsu_aw_addr  = wfix ? 64'h8000_2000 : {$urandom, $urandom};
    lsu_w_data   = wfix ? 64'h11 : {$urandom, $urandom};
    lsu_w_strb   = wfix ? 8'h01 : 8'($urandom);
    lsu_aw_valid = wfix | 1'($urandom);
    lsu_w_valid  = wfix | 1'($urandom);
    mem_b_resp   = wfix ? 2'b00 : 2'($urandom);
    mem_b_valid  = wfix | 1'($urandom);
    {mem_aw_ready, mem_w_ready, lsu_b_ready} = 3'($urandom);
    #1;
    if (!busy) begin
      chk("idle_arvalid", 64'(mem_ar_valid), 64'd0);
      chk("idle_arready", 64'({ifu_ar_ready, lsu_ar_ready}), 64'd0);
    end else if (!ar_done) begin
      chk("ar_addr", mem_ar_addr, g ? l_addr : i_addr);
      chk("ar_valid", 64'(mem_ar_valid), 64'd1);
      chk("ar_ready", 64'({ifu_ar_ready, lsu_ar_ready}), g ? 64'({1'b0, mem_ar_ready}) : 64'({mem_ar_ready, 1'b0}));
    end
    chk("ifu_r_ctl", 64'({ifu_r_valid, ifu_r_resp}), (busy && ar_done && !g) ? 64'({mem_r_valid, mem_r_resp}) : 64'd0);
    chk("ifu_r_data", ifu_r_data, (busy && ar_done && !g) ? mem_r_data : 64'd0);
    chk("lsu_r_ctl", 64'({lsu_r_valid, lsu_r_resp}), (busy && ar_done && g) ? 64'({mem_r_valid, mem_r_resp}) : 64'd0);
    chk("lsu_r_data", lsu_r_data, (busy && ar_done && g) ? mem_r_data : 64'd0);
    chk("mem_r_ready", 64'(mem_r_ready), (busy && ar_done) ? 64'(g ? lsu_r_ready : ifu_r_ready) : 64'd0);
    chk("aw_addr", mem_aw_addr, lsu_aw_addr);
    chk("w_data", mem_w_data, lsu_w_data);
    chk("wr_ctl", 64'({mem_aw_valid, mem_w_strb, mem_w_valid, mem_b_ready, lsu_aw_ready, lsu_w_ready, lsu_b_valid, lsu_b_resp}),
        64'({lsu_aw_valid, lsu_w_strb, lsu_w_valid, lsu_b_ready, mem_aw_ready, mem_w_ready, mem_b_valid, mem_b_resp}));
    if (m_st == 1) begin
      if (m_dly == 0) m_st = 2;
      else m_dly--;
    end
    if (busy && ar_done && g && mem_r_valid && lsu_stall > 0) lsu_stall--;
    if (!busy) begin
      if (ifu_ar_valid || lsu_ar_valid) begin
`ifdef YSYX_22051013_ARB_RR_EN
        g = (ifu_ar_valid && lsu_ar_valid) ? !last : lsu_ar_valid;
        last = g;
`else
        g = lsu_ar_valid;
`endif
        gq.push_back(g);
        busy = 1; ar_done = 0;
      end
    end else if (!ar_done) begin
      if (mem_ar_ready) begin
        a = g ? l_addr : i_addr;
        arq.push_back(a);
        ar_done = 1;
        m_data = fixed_en ? fixed_data : fdat(a);
        m_resp = a[4:3];
        m_st = 1; m_dly = $urandom_range(3);
        if (g) begin l_st = 2; l_exp = m_data; end
        else begin i_st = 2; i_exp = m_data; end
      end
    end else if (mem_r_valid && (g ? lsu_r_ready : ifu_r_ready)) begin
      busy = 0; m_st = 0;
      if (g) begin chk("lsu_rx", lsu_r_data, l_exp); l_st = keep ? 1 : 0; end
      else begin chk("ifu_rx", ifu_r_data, i_exp); i_st = keep ? 1 : 0; end
    end
    if (i_st == 0 && req_pct > 0 && $urandom_range(99) < req_pct) begin i_st = 1; i_addr = {$urandom, $urandom}; end
    if (l_st == 0 && req_pct > 0 && $urandom_range(99) < req_pct) begin l_st = 1; l_addr = {$urandom, $urandom}; end
    @(negedge clk);
  endtask

  task automatic run_idle();
    int n = 0;
    while ((busy || i_st != 0 || l_st != 0) && n < 500) begin cycle(); n++; end
    if (n >= 500) chk("timeout", 64'd1, 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    chk(tag, 64'({mem_ar_valid, ifu_ar_ready, lsu_ar_ready, ifu_r_valid, lsu_r_valid, mem_r_ready, ifu_r_resp, lsu_r_resp}), 64'd0);
    chk({tag, "_data"}, ifu_r_data | lsu_r_data | mem_ar_addr, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    {ifu_ar_valid, lsu_ar_valid, ifu_r_ready, lsu_r_ready, mem_ar_ready} = '0;
    mem_r_valid = 1; mem_r_data = 64'hffff; mem_r_resp = 2'b11;
    #1;
    check_quiet("reset");
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    req_pct = 0; fixed_en = 0; wfix = 0; fixed_data = '0; i_addr = '0; l_addr = '0;
    @(negedge clk);
    do_reset();
    // IFU alone with a concurrent fixed LSU write
    fixed_en = 1; fixed_data = 64'hDEAD_BEEF_0000_0001; wfix = 1;
    i_st = 1; i_addr = 64'h8000_0000;
    cycle();
    chk("lat_arvalid", 64'(mem_ar_valid), 64'd1);
    run_idle();
    chk("t1_addr", arq[0], 64'h8000_0000);
    chk("t1_data", i_exp, 64'hDEAD_BEEF_0000_0001);
    chk("t1_bresp", 64'(lsu_b_resp), 64'd0);
    fixed_en = 0; wfix = 0;
    // simultaneous requests
    arq.delete(); gq.delete();
    i_st = 1; i_addr = 64'h8000_0000; l_st = 1; l_addr = 64'h8000_1000;
    run_idle();
    chk("pri_first", arq[0], 64'h8000_1000);
    chk("pri_second", arq[1], 64'h8000_0000);
    // LSU holds off r_ready while IFU waits
    gq.delete();
    i_st = 1; i_addr = 64'h8000_3000; l_st = 1; l_addr = 64'h8000_4000; lsu_stall = 3;
    run_idle();
    chk("stall_done", 64'(lsu_stall), 64'd0);
    chk("stall_order", 64'({gq[0], gq[1]}), 64'b10);
    // continuous requests from both
    gq.delete(); keep = 1;
    i_st = 1; i_addr = 64'h8000_5000; l_st = 1; l_addr = 64'h8000_6000;
    for (int n = 0; n < 400 && gq.size() < 4; n++) cycle();
    keep = 0;
    run_idle();
    if (gq.size() < 4) chk("cont_count", 64'(gq.size()), 64'd4);
    else
`ifdef YSYX_22051013_ARB_RR_EN
      chk("cont_order", 64'({gq[0], gq[1], gq[2], gq[3]}), 64'b1010);
`else
      chk("cont_order", 64'({gq[0], gq[1], gq[2], gq[3]}), 64'b1111);
`endif
    // reset while in DATA
    l_st = 1; l_addr = 64'h8000_7000;
    for (int n = 0; n < 100 && !(busy && ar_done); n++) cycle();
    chk("reach_data", 64'(busy && ar_done), 64'd1);
    rst = 1; #1;
    check_quiet("mid_rst");
    @(negedge clk);
    do_reset();
    i_st = 1; i_addr = 64'h8000_8000;
    run_idle();
    chk("post_rst_grant", 64'(gq.size() == 1 && gq[0] == 1'b0), 64'd1);
    chk("post_rst_addr", arq[0], 64'h8000_8000);
    // random traffic
    req_pct = 30;
    repeat (2000) cycle();
    req_pct = 0;
    run_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
